// File: rtl/mm_pkg.sv
// Shared types and default sizing for the matrix-multiplier compute path.
package mm_pkg;

    localparam int MAX_N_DEF  = 8;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int ADDR_W_DEF = 6;
    localparam int PROD_W_DEF = 2 * DATA_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Full-precision width of an unsigned DATA_W x DATA_W product.
    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/mm_mac_unit.sv
// Multiply-accumulate stage plus the result-RAM write register.
// Operands arrive one cycle after the read issue; a finished element is
// presented on c_we/c_addr/c_data one cycle after its last accumulate.
module mm_mac_unit
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              first,
    input  logic              last,
    input  logic [ADDR_W-1:0] tag,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [ACC_W-1:0]  c_data,
    output logic              ovf_hit
);

    localparam int PROD_W = prod_width(DATA_W);
    // One spare bit above the wider operand keeps the sum exact for overflow detection.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum_full;
    logic [ACC_W-1:0]  acc_reg;
    logic              c_we_reg;
    logic [ADDR_W-1:0] c_addr_reg;
    logic [ACC_W-1:0]  c_data_reg;

    // Untruncated product and running sum; first restarts the dot product.
    always_comb begin
        prod     = PROD_W'(a_data) * PROD_W'(b_data);
        sum_full = (first ? SUM_W'(0) : SUM_W'(acc_reg)) + SUM_W'(prod);
        ovf_hit  = valid && (sum_full[SUM_W-1:ACC_W] != '0);
    end

    // Accumulator and output register; the written value is the truncated sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg    <= '0;
            c_we_reg   <= 1'b0;
            c_addr_reg <= '0;
            c_data_reg <= '0;
        end else begin
            c_we_reg <= valid && last;
            if (valid) begin
                acc_reg <= sum_full[ACC_W-1:0];
            end
            if (valid && last) begin
                c_addr_reg <= tag;
                c_data_reg <= sum_full[ACC_W-1:0];
            end
        end
    end

    assign c_we   = c_we_reg;
    assign c_addr = c_addr_reg;
    assign c_data = c_data_reg;

endmodule

// File: rtl/mm_mac_sequencer.sv
// Compute-phase sequencer: walks i/j/k (k innermost) for C = A x B, issuing one
// A/B read per cycle and feeding a single MAC whose results go to the C RAM.
module mm_mac_sequencer
    import mm_pkg::*;
#(
    parameter int MAX_N  = MAX_N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [ACC_W-1:0]  c_data
);

    state_t            state_reg;
    logic [3:0]        n_reg, i_reg, j_reg, k_reg;
    logic [3:0]        i_next, j_next, k_next;
    logic              k_wrap, j_wrap, last_issue, size_ok;
    logic [ADDR_W-1:0] a_addr_next, b_addr_next, tag_now;
    logic [ADDR_W-1:0] a_addr_reg, b_addr_reg;
    logic              rd_en_reg, busy_reg, done_reg, err_reg, ovf_reg, drain_reg;
    logic              s1_valid_reg, s1_first_reg, s1_last_reg;
    logic [ADDR_W-1:0] s1_tag_reg;
    logic              ovf_hit;

    // Loop-nest successor and the addresses of the next issue.
    always_comb begin
        size_ok     = (size != 4'd0) && (int'(size) <= MAX_N);
        k_wrap      = (k_reg == n_reg - 4'd1);
        j_wrap      = (j_reg == n_reg - 4'd1);
        last_issue  = k_wrap && j_wrap && (i_reg == n_reg - 4'd1);
        k_next      = k_wrap ? 4'd0 : k_reg + 4'd1;
        j_next      = k_wrap ? (j_wrap ? 4'd0 : j_reg + 4'd1) : j_reg;
        i_next      = (k_wrap && j_wrap) ? i_reg + 4'd1 : i_reg;
        a_addr_next = ADDR_W'(i_next) * ADDR_W'(n_reg) + ADDR_W'(k_next);
        b_addr_next = ADDR_W'(k_next) * ADDR_W'(n_reg) + ADDR_W'(j_next);
        tag_now     = ADDR_W'(i_reg) * ADDR_W'(n_reg) + ADDR_W'(j_reg);
    end

    // Control FSM: accepts/rejects start, steps counters, drains the MAC pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            n_reg      <= '0;
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            a_addr_reg <= '0;
            b_addr_reg <= '0;
            rd_en_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            drain_reg  <= 1'b0;
        end else begin
            err_reg  <= 1'b0;
            done_reg <= 1'b0;
            if (ovf_hit) begin
                ovf_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start && size_ok) begin
                        state_reg  <= RUN;
                        n_reg      <= size;
                        i_reg      <= '0;
                        j_reg      <= '0;
                        k_reg      <= '0;
                        a_addr_reg <= '0;
                        b_addr_reg <= '0;
                        rd_en_reg  <= 1'b1;
                        busy_reg   <= 1'b1;
                        ovf_reg    <= 1'b0;
                    end else if (start) begin
                        err_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state_reg  <= DRAIN;
                        rd_en_reg  <= 1'b0;
                        drain_reg  <= 1'b0;
                        i_reg      <= '0;
                        j_reg      <= '0;
                        k_reg      <= '0;
                        a_addr_reg <= '0;
                        b_addr_reg <= '0;
                    end else begin
                        i_reg      <= i_next;
                        j_reg      <= j_next;
                        k_reg      <= k_next;
                        a_addr_reg <= a_addr_next;
                        b_addr_reg <= b_addr_next;
                    end
                end
                DRAIN: begin
                    if (!drain_reg) begin
                        drain_reg <= 1'b1;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        drain_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rd_en_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Issue-side tags travel alongside the RAM read so they meet the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_tag_reg   <= '0;
        end else begin
            s1_valid_reg <= rd_en_reg;
            s1_first_reg <= (k_reg == 4'd0);
            s1_last_reg  <= k_wrap;
            s1_tag_reg   <= tag_now;
        end
    end

    mm_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .valid   (s1_valid_reg),
        .first   (s1_first_reg),
        .last    (s1_last_reg),
        .tag     (s1_tag_reg),
        .a_data  (a_data),
        .b_data  (b_data),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_data  (c_data),
        .ovf_hit (ovf_hit)
    );

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign err    = err_reg;
    assign ovf    = ovf_reg;
    assign rd_en  = rd_en_reg;
    assign a_addr = a_addr_reg;
    assign b_addr = b_addr_reg;

endmodule

// File: tb/tb_mm_mac_sequencer.sv
// Scoreboard bench for mm_mac_sequencer: drivers queue expected C writes,
// a negedge monitor pops and compares each write and done pulse.
module tb_mm_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] size = 4'd0;
    logic       busy, done, err, ovf, rd_en, c_we;
    logic [5:0] a_addr, b_addr, c_addr;
    logic [7:0] a_data = 8'd0;
    logic [7:0] b_data = 8'd0;
    logic [15:0] c_data;

    logic [7:0] a_mem [64];
    logic [7:0] b_mem [64];

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int t0 = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int exp_done_cyc = -1;
    int mon_cyc;

    mm_mac_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .size   (size),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .ovf    (ovf),
        .rd_en  (rd_en),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .a_data (a_data),
        .b_data (b_data),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_data (c_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Operand RAMs with registered read.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[a_addr];
            b_data <= b_mem[b_addr];
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every C write and done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            mon_cyc = edge_cnt - t0 + 1;
            if (rd_en) rd_cnt++;
            if (c_we) begin
                if (exp_q.size() == 0) begin
                    check("c_we_unexpected", c_we, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("c_write addr=%0d data=%0d cycle=%0d", c_addr, c_data, mon_cyc);
                    check("c_addr", c_addr, mon_e.addr);
                    check("c_data", c_data, mon_e.data);
                    check("c_write_cycle", mon_cyc, mon_e.cyc);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_cycle", mon_cyc, exp_done_cyc);
                check("done_with_c_we", c_we, 1);
            end
        end
    end

    task automatic push_wr(input int addr, input int data, input int cyc);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    // Presents start for one edge (edge 0); returns inside cycle 1.
    task automatic start_run(input logic [3:0] sz);
        @(negedge clk);
        size  = sz;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = edge_cnt;
        start = 1'b0;
        size  = 4'd0;
    endtask

    task automatic wait_cycle(input int c);
        int guard = 0;
        @(negedge clk);
        while ((edge_cnt - t0 + 1) < c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic wait_idle(input int exp_fall);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("busy_fall_cycle", edge_cnt - t0 + 1, exp_fall);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_a_addr"}, a_addr, 0);
        check({tag, "_b_addr"}, b_addr, 0);
        check({tag, "_c_we"}, c_we, 0);
        check({tag, "_c_addr"}, c_addr, 0);
        check({tag, "_c_data"}, c_data, 0);
    endtask

    task automatic run_2x2_small();
        int rd0;
        int dn0;
        a_mem[0] = 8'd1; a_mem[1] = 8'd2; a_mem[2] = 8'd3; a_mem[3] = 8'd4;
        b_mem[0] = 8'd5; b_mem[1] = 8'd6; b_mem[2] = 8'd7; b_mem[3] = 8'd8;
        push_wr(0, 19, 4);
        push_wr(1, 22, 6);
        push_wr(2, 43, 8);
        push_wr(3, 50, 10);
        exp_done_cyc = 10;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        $display("run size=2 small operands");
        start_run(4'd2);
        @(negedge clk);
        check("ovf_cleared_on_start", ovf, 0);
        check("busy_cycle1", busy, 1);
        wait_idle(11);
        check("rd_count_2x2", rd_cnt - rd0, 8);
        check("done_count_2x2", done_cnt - dn0, 1);
        check("ovf_2x2", ovf, 0);
        check("pending_2x2", exp_q.size(), 0);
    endtask

    initial begin
        int rd0;
        int dn0;
        for (int i = 0; i < 64; i++) begin
            a_mem[i] = 8'd0;
            b_mem[i] = 8'd0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // 2x2 main case
        run_2x2_small();

        // N=1 degenerate case
        a_mem[0] = 8'd7;
        b_mem[0] = 8'd9;
        push_wr(0, 63, 3);
        exp_done_cyc = 3;
        rd0 = rd_cnt;
        $display("run size=1");
        start_run(4'd1);
        wait_idle(4);
        check("rd_count_1x1", rd_cnt - rd0, 1);
        check("pending_1x1", exp_q.size(), 0);

        // Illegal sizes
        for (int s = 0; s < 2; s++) begin
            logic [3:0] bad_sz;
            bad_sz = (s == 0) ? 4'd0 : 4'd9;
            rd0 = rd_cnt;
            $display("start with illegal size=%0d", bad_sz);
            start_run(bad_sz);
            @(negedge clk);
            check("err_pulse", err, 1);
            check("err_busy", busy, 0);
            check("err_rd_en", rd_en, 0);
            @(negedge clk);
            check("err_one_cycle", err, 0);
            check("err_busy_after", busy, 0);
            check("err_no_reads", rd_cnt - rd0, 0);
        end

        // Overflow: all operands 255
        for (int i = 0; i < 4; i++) begin
            a_mem[i] = 8'd255;
            b_mem[i] = 8'd255;
        end
        for (int e = 0; e < 4; e++) push_wr(e, 64514, (e + 1) * 2 + 2);
        exp_done_cyc = 10;
        $display("run size=2 overflow operands");
        start_run(4'd2);
        wait_idle(11);
        check("ovf_set", ovf, 1);
        check("pending_ovf", exp_q.size(), 0);

        // Next accepted start clears ovf
        run_2x2_small();

        // 3x3 identity with an ignored start in cycle 5
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                a_mem[i * 3 + k] = (i == k) ? 8'd1 : 8'd0;
                b_mem[i * 3 + k] = 8'(i * 3 + k + 1);
            end
        end
        for (int e = 0; e < 9; e++) push_wr(e, e + 1, (e + 1) * 3 + 2);
        exp_done_cyc = 29;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        $display("run size=3 identity, start pulse in cycle 5");
        start_run(4'd3);
        wait_cycle(5);
        start = 1'b1;
        size  = 4'd2;
        wait_cycle(6);
        start = 1'b0;
        size  = 4'd0;
        wait_idle(30);
        check("rd_count_3x3", rd_cnt - rd0, 27);
        check("done_count_3x3", done_cnt - dn0, 1);
        check("pending_3x3", exp_q.size(), 0);

        // Reset in cycle 12 of a 3x3 run
        for (int e = 0; e < 3; e++) push_wr(e, e + 1, (e + 1) * 3 + 2);
        exp_done_cyc = -1;
        dn0 = done_cnt;
        $display("run size=3, reset in cycle 12");
        start_run(4'd3);
        wait_cycle(12);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("pending_before_reset", exp_q.size(), 0);
        repeat (30) @(negedge clk);
        check("busy_after_abort", busy, 0);
        check("no_done_after_abort", done_cnt - dn0, 0);

        // Fresh run after reset release
        run_2x2_small();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
